// File: rtl/terminal_sched_if.sv
// Bus bundle between the store/debug requesters, the terminal scheduler and the terminal block.
// master = requester/terminal side, slave = the scheduler itself.
interface terminal_sched_if #(
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          cpu_we;
    logic [31:0]   cpu_addr;
    logic [31:0]   cpu_wdata;
    logic          cpu_stall;
    logic          dbg_valid;
    logic [7:0]    dbg_data;
    logic          dbg_ready;
    logic          term_we;
    logic [31:0]   term_addr;
    logic [31:0]   term_data;
    logic [CW-1:0] fifo_count;
    logic          busy;

    modport master (
        output cpu_we, cpu_addr, cpu_wdata, dbg_valid, dbg_data,
        input  cpu_stall, dbg_ready, term_we, term_addr, term_data, fifo_count, busy
    );

    modport slave (
        input  cpu_we, cpu_addr, cpu_wdata, dbg_valid, dbg_data,
        output cpu_stall, dbg_ready, term_we, term_addr, term_data, fifo_count, busy
    );
endinterface

// File: rtl/terminal_sched.sv
// Round-robin CPU/debug byte scheduler feeding the terminal port through a paced FIFO drain.
// Optional macro TERM_SCHED_CRLF_EN expands each 8'h0A into a 8'h0D, 8'h0A pair.
module terminal_sched #(
    parameter int          DEPTH     = 8,
    parameter int          CHAR_GAP  = 4,
    parameter logic [31:0] TERM_BASE = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             reset,
    terminal_sched_if.slave  bus,
    output logic [1:0]       fsm_state
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int GW = $clog2(CHAR_GAP + 2);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SEND = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;
`ifdef TERM_SCHED_CRLF_EN
    localparam logic [1:0] CR   = 2'd3;
`endif

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [GW-1:0] gap_cnt;
    logic [GW-1:0] gap_nxt;
    logic          last_grant_dbg;
    logic          term_we_q;
    logic          term_we_nxt;
    logic [31:0]   term_data_q;
    logic [31:0]   term_data_nxt;
    logic [31:0]   term_addr_q;

    logic          cpu_req;
    logic          space;
    logic          grant_cpu;
    logic          grant_dbg;
    logic          push;
    logic          pop;
    logic          issue;
    logic [7:0]    push_byte;
    logic [7:0]    head;

    logic          unused_bits;
    assign unused_bits = ^{bus.cpu_addr[7:0], bus.cpu_wdata[31:8]};

    assign head = mem[rd_ptr];

    // Handshake: a requester's byte is taken on the rising edge of any cycle in which
    // it is granted (CPU: cpu_req && !cpu_stall, debug: dbg_valid && dbg_ready). Both
    // strobes are combinational and the requester must hold its byte until taken.
    always_comb begin
        cpu_req   = bus.cpu_we && (bus.cpu_addr[31:8] == 24'h0);
        space     = (count < CW'(DEPTH)) || pop;
        grant_cpu = 1'b0;
        grant_dbg = 1'b0;
        if (!reset && space) begin
            if (cpu_req && (!bus.dbg_valid || last_grant_dbg))
                grant_cpu = 1'b1;
            else if (bus.dbg_valid)
                grant_dbg = 1'b1;
        end
        push      = grant_cpu || grant_dbg;
        push_byte = grant_cpu ? bus.cpu_wdata[7:0] : bus.dbg_data;
    end

    assign bus.cpu_stall = !reset && cpu_req && !grant_cpu;
    assign bus.dbg_ready = grant_dbg;

    // Drain FSM; 'issue' marks a cycle that starts a new character from the FIFO head.
    always_comb begin
        state_nxt     = state;
        gap_nxt       = gap_cnt;
        term_we_nxt   = 1'b0;
        term_data_nxt = term_data_q;
        pop           = 1'b0;
        issue         = 1'b0;
        case (state)
            IDLE: issue = (count != '0);
            SEND: begin
                if (CHAR_GAP == 0) begin
                    if (count != '0)
                        issue = 1'b1;
                    else
                        state_nxt = IDLE;
                end else begin
                    gap_nxt   = GW'(CHAR_GAP - 1);
                    state_nxt = GAP;
                end
            end
            GAP: begin
                if (gap_cnt == '0)
                    state_nxt = IDLE;
                else
                    gap_nxt = gap_cnt - 1'b1;
            end
`ifdef TERM_SCHED_CRLF_EN
            CR: begin
                // The LF is still the FIFO head; it is popped only when it is finally sent.
                if (gap_cnt == '0) begin
                    term_we_nxt   = 1'b1;
                    term_data_nxt = {24'h0, 8'h0A};
                    pop           = 1'b1;
                    state_nxt     = SEND;
                end else begin
                    gap_nxt = gap_cnt - 1'b1;
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase

        if (issue) begin
            term_we_nxt = 1'b1;
`ifdef TERM_SCHED_CRLF_EN
            if (head == 8'h0A) begin
                // Wait CHAR_GAP+2 cycles (or 1 when unpaced) before the LF goes out.
                term_data_nxt = {24'h0, 8'h0D};
                gap_nxt       = (CHAR_GAP == 0) ? '0 : GW'(CHAR_GAP + 1);
                state_nxt     = CR;
            end else begin
                term_data_nxt = {24'h0, head};
                pop           = 1'b1;
                state_nxt     = SEND;
            end
`else
            term_data_nxt = {24'h0, head};
            pop           = 1'b1;
            state_nxt     = SEND;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            gap_cnt        <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            last_grant_dbg <= 1'b1;
            term_we_q      <= 1'b0;
            term_data_q    <= '0;
            term_addr_q    <= TERM_BASE;
        end else begin
            state       <= state_nxt;
            gap_cnt     <= gap_nxt;
            term_we_q   <= term_we_nxt;
            term_data_q <= term_data_nxt;
            term_addr_q <= TERM_BASE;
            count       <= count + CW'(push) - CW'(pop);
            if (push) begin
                wr_ptr         <= wr_ptr + 1'b1;
                last_grant_dbg <= grant_dbg;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage is not reset: stale entries are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= push_byte;
    end

    assign bus.term_we    = term_we_q;
    assign bus.term_addr  = term_addr_q;
    assign bus.term_data  = term_data_q;
    assign bus.fifo_count = count;
    assign bus.busy       = (count != '0) || (state != IDLE);
    assign fsm_state      = state;
endmodule
